// File: rtl/iq_sweep_controller_pkg.sv
// Shared types and sizing helpers for the IQ sweep controller slice.
package iq_ctrl_pkg;
  localparam int PHASE_W_DEF  = 32;
  localparam int SAMPLE_W_DEF = 14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACCUM,
    ST_EMIT
  } sweep_state_t;

  // A sum of 2^avg_log2 samples needs avg_log2 guard bits above the sample width.
  function automatic int acc_width(input int sample_w, input int avg_log2);
    return sample_w + avg_log2;
  endfunction
endpackage

// File: rtl/iq_sweep_controller_if.sv
// Averaged-result stream: one record per sweep step over a valid/ready handshake.
interface iq_sweep_controller_if
  import iq_ctrl_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int STEP_W   = 16
);
  logic                       resultValid;
  logic                       resultReady;
  logic signed [SAMPLE_W-1:0] resultI;
  logic signed [SAMPLE_W-1:0] resultQ;
  logic [STEP_W-1:0]          resultIdx;

  modport master (
    output resultValid, resultI, resultQ, resultIdx,
    input  resultReady
  );

  modport slave (
    input  resultValid, resultI, resultQ, resultIdx,
    output resultReady
  );
endinterface

// File: rtl/iq_sweep_controller_accumulator.sv
// Paired signed I/Q accumulators with a sample counter; sum outputs include the sample being offered.
module iq_accumulator
  import iq_ctrl_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int AVG_LOG2 = 4,
  parameter int ACC_W    = acc_width(SAMPLE_W, AVG_LOG2)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       en,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic signed [SAMPLE_W-1:0] sample_q,
  output logic signed [ACC_W-1:0]    sum_i,
  output logic signed [ACC_W-1:0]    sum_q,
  output logic                       full
);
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic signed [ACC_W-1:0] acc_i, acc_q;
  logic [CNT_W-1:0]        count;

  assign sum_i = acc_i + ACC_W'(sample_i);
  assign sum_q = acc_q + ACC_W'(sample_q);
  // full means the next enabled sample completes the averaging block
  assign full  = (count == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc_i <= '0;
      acc_q <= '0;
      count <= '0;
    end else if (en) begin
      acc_i <= sum_i;
      acc_q <= sum_q;
      count <= count + CNT_ONE;
    end
  end
endmodule

// File: rtl/iq_sweep_controller.sv
// Stepped-frequency sweep sequencer: drives the NCO increment, waits for settling, averages I/Q per step.
module iq_sweep_controller
  import iq_ctrl_pkg::*;
#(
  parameter int PHASE_W       = PHASE_W_DEF,
  parameter int SAMPLE_W      = SAMPLE_W_DEF,
  parameter int SETTLE_CYCLES = 1024,
  parameter int AVG_LOG2      = 4,
  parameter int STEP_W        = 16
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [PHASE_W-1:0]         startInc,
  input  logic [PHASE_W-1:0]         stepInc,
  input  logic [STEP_W-1:0]          numSteps,
  input  logic                       ncoValid,
  input  logic [1:0]                 filtValid,
  input  logic signed [SAMPLE_W-1:0] I,
  input  logic signed [SAMPLE_W-1:0] Q,
  output logic [PHASE_W-1:0]         phaseInc,
  iq_sweep_controller_if.master      res,
  output logic                       busy,
  output logic                       done
);
  localparam int ACC_W = acc_width(SAMPLE_W, AVG_LOG2);
  localparam logic [15:0]       SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0]       SETTLE_ONE  = 16'd1;
  localparam logic [STEP_W-1:0] STEP_ONE    = STEP_W'(1);

  sweep_state_t state, state_next;

  logic [PHASE_W-1:0]         phase_inc, step_inc_q;
  logic [STEP_W-1:0]          num_steps_q, idx, result_idx;
  logic [15:0]                settle_cnt;
  logic signed [SAMPLE_W-1:0] result_i, result_q;
  logic                       done_q;
  logic                       load, empty_start, acc_clear, acc_en, capture, advance, finish;
  logic signed [ACC_W-1:0]    sum_i, sum_q;
  logic                       acc_full;

  iq_accumulator #(
    .SAMPLE_W (SAMPLE_W),
    .AVG_LOG2 (AVG_LOG2),
    .ACC_W    (ACC_W)
  ) u_acc (
    .clk      (CLK),
    .reset    (reset),
    .clear    (acc_clear),
    .en       (acc_en),
    .sample_i (I),
    .sample_q (Q),
    .sum_i    (sum_i),
    .sum_q    (sum_q),
    .full     (acc_full)
  );

  always_ff @(posedge CLK) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // abort is tested first in every active state so it beats a same-cycle acceptance
  always_comb begin
    state_next  = state;
    load        = 1'b0;
    empty_start = 1'b0;
    acc_clear   = 1'b0;
    acc_en      = 1'b0;
    capture     = 1'b0;
    advance     = 1'b0;
    finish      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (numSteps != '0) begin
            load       = 1'b1;
            state_next = ST_SETTLE;
          end else begin
            empty_start = 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (ncoValid && settle_cnt == SETTLE_LAST) begin
          acc_clear  = 1'b1;
          state_next = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (filtValid == 2'b11) begin
          acc_en = 1'b1;
          if (acc_full) begin
            capture    = 1'b1;
            state_next = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (res.resultReady) begin
          if (idx == num_steps_q - STEP_ONE) begin
            finish     = 1'b1;
            state_next = ST_IDLE;
          end else begin
            advance    = 1'b1;
            state_next = ST_SETTLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      phase_inc   <= '0;
      step_inc_q  <= '0;
      num_steps_q <= '0;
      idx         <= '0;
      settle_cnt  <= '0;
      result_i    <= '0;
      result_q    <= '0;
      result_idx  <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= empty_start | finish;
      if (load) begin
        phase_inc   <= startInc;
        step_inc_q  <= stepInc;
        num_steps_q <= numSteps;
        idx         <= '0;
        settle_cnt  <= '0;
      end else if (advance) begin
        idx        <= idx + STEP_ONE;
        phase_inc  <= phase_inc + step_inc_q;
        settle_cnt <= '0;
      end else if (state == ST_SETTLE && ncoValid) begin
        settle_cnt <= settle_cnt + SETTLE_ONE;
      end
      // Arithmetic shift floors the mean toward minus infinity
      if (capture) begin
        result_i   <= SAMPLE_W'(sum_i >>> AVG_LOG2);
        result_q   <= SAMPLE_W'(sum_q >>> AVG_LOG2);
        result_idx <= idx;
      end
    end
  end

  assign phaseInc        = phase_inc;
  assign busy            = (state != ST_IDLE);
  assign done            = done_q;
  assign res.resultValid = (state == ST_EMIT);
  assign res.resultI     = result_i;
  assign res.resultQ     = result_q;
  assign res.resultIdx   = result_idx;
endmodule

// File: tb/tb_iq_sweep_controller.sv
// Self-checking bench for iq_sweep_controller: vector table, directed corner sequences, randomized model run.
module tb_iq_sweep_controller;
  localparam int PW  = 32;
  localparam int SW  = 14;
  localparam int SC  = 4;
  localparam int AL  = 2;
  localparam int STW = 16;
  localparam int NS  = 1 << AL;

  logic                 CLK = 1'b0;
  logic                 reset, start, abort, ncoValid;
  logic [PW-1:0]        startInc, stepInc, phaseInc;
  logic [STW-1:0]       numSteps;
  logic [1:0]           filtValid;
  logic signed [SW-1:0] I, Q;
  logic                 busy, done;

  iq_sweep_controller_if #(.SAMPLE_W(SW), .STEP_W(STW)) res ();

  iq_sweep_controller #(
    .PHASE_W(PW), .SAMPLE_W(SW), .SETTLE_CYCLES(SC), .AVG_LOG2(AL), .STEP_W(STW)
  ) dut (
    .CLK(CLK), .reset(reset), .start(start), .abort(abort),
    .startInc(startInc), .stepInc(stepInc), .numSteps(numSteps),
    .ncoValid(ncoValid), .filtValid(filtValid), .I(I), .Q(Q),
    .phaseInc(phaseInc), .res(res), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string name;
    int    si[NS];
    int    sq[NS];
    int    ei;
    int    eq;
  } vec_t;
  vec_t vecs[6];

  bit            mActive, mPending, mDone;
  int            mSettle, mCount, mSumI, mSumQ, mIdx, mSteps, mResI, mResQ;
  logic [PW-1:0] mPhase, mStep;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input bit st, input bit ab, input bit nco, input logic [1:0] fv,
                               input int si, input int sq, input bit rdy);
    start           = st;
    abort           = ab;
    ncoValid        = nco;
    filtValid       = fv;
    I               = SW'(si);
    Q               = SW'(sq);
    res.resultReady = rdy;
    tick();
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0);
    reset = 1'b0;
  endtask

  task automatic startSweep(input logic [PW-1:0] si, input logic [PW-1:0] st, input int ns);
    startInc = si;
    stepInc  = st;
    numSteps = STW'(ns);
    applyStimulus(1, 0, 1, 2'b00, 0, 0, 0);
  endtask

  task automatic settleAndFill(input int si, input int sq);
    for (int k = 0; k < SC; k++) applyStimulus(0, 0, 1, 2'b00, 0, 0, 0);
    for (int k = 0; k < NS; k++) applyStimulus(0, 0, 1, 2'b11, si, sq, 0);
  endtask

  function automatic int floorDiv(input int s, input int n);
    int q;
    q = s / n;
    if ((s % n) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  // Transaction-level reference: settle counts NCO-valid cycles, then the next NS full-valid samples are averaged
  task automatic modelEdge(input bit st, input bit nco, input logic [1:0] fv,
                           input int si, input int sq, input bit rdy);
    mDone = 1'b0;
    if (!mActive) begin
      if (st && numSteps != '0) begin
        mActive = 1'b1;
        mPhase  = startInc;
        mStep   = stepInc;
        mSteps  = int'(numSteps);
        mIdx    = 0;
        mSettle = 0;
        mCount  = 0;
        mSumI   = 0;
        mSumQ   = 0;
      end else if (st) begin
        mDone = 1'b1;
      end
    end else if (mPending) begin
      if (rdy) begin
        mPending = 1'b0;
        if (mIdx == mSteps - 1) begin
          mActive = 1'b0;
          mDone   = 1'b1;
        end else begin
          mIdx++;
          mPhase  = mPhase + mStep;
          mSettle = 0;
          mCount  = 0;
          mSumI   = 0;
          mSumQ   = 0;
        end
      end
    end else if (mSettle < SC) begin
      if (nco) mSettle++;
    end else if (fv == 2'b11) begin
      mSumI += si;
      mSumQ += sq;
      mCount++;
      if (mCount == NS) begin
        mPending = 1'b1;
        mResI    = floorDiv(mSumI, NS);
        mResQ    = floorDiv(mSumQ, NS);
      end
    end
  endtask

  initial begin
    int  got;
    bit  doneSeen;
    int  cycles;
    bit  st, nco, rdy;
    logic [1:0] fv;
    int  si, sq;

    vecs[0] = '{"const",     '{100, 100, 100, 100},         '{-100, -100, -100, -100}, 100,   -100};
    vecs[1] = '{"floor_neg", '{1, 2, 3, -7},                '{-1, -1, -1, -2},        -1,    -2};
    vecs[2] = '{"extremes",  '{-8192, -8192, -8192, -8192}, '{8191, 8191, 8191, 8191}, -8192, 8191};
    vecs[3] = '{"mixed",     '{5, 5, 5, 6},                 '{-3, 0, 0, 0},            5,     -1};
    vecs[4] = '{"span",      '{8191, 8191, -8192, -8192},   '{2, 2, 2, 1},            -1,    1};
    vecs[5] = '{"quarter",   '{-4, -4, -4, -4},             '{3, 0, 0, 0},            -4,    0};

    reset = 1'b0; start = 1'b0; abort = 1'b0; ncoValid = 1'b0; filtValid = 2'b00;
    I = '0; Q = '0; startInc = '0; stepInc = '0; numSteps = '0; res.resultReady = 1'b0;

    doReset();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_valid", res.resultValid, 0);
    checkOutput("rst_phase", phaseInc, 0);
    checkOutput("rst_idx", res.resultIdx, 0);
    checkOutput("rst_resI", res.resultI, 0);

    // Three-step sweep with ready held high and constant samples
    startInc = 32'h1000; stepInc = 32'h100; numSteps = 16'd3;
    applyStimulus(1, 0, 1, 2'b11, 100, -100, 1);
    checkOutput("t1_busy", busy, 1);
    checkOutput("t1_phase0", phaseInc, 32'h1000);
    got = 0; doneSeen = 0;
    for (int c = 0; c < 200 && !doneSeen; c++) begin
      if (res.resultValid) begin
        if (got < 3) begin
          checkOutput("t1_idx", res.resultIdx, got);
          checkOutput("t1_I", res.resultI, 100);
          checkOutput("t1_Q", res.resultQ, -100);
          checkOutput("t1_phase", phaseInc, 32'h1000 + 32'h100 * got);
        end
        got++;
      end
      if (done) doneSeen = 1;
      applyStimulus(0, 0, 1, 2'b11, 100, -100, 1);
    end
    checkOutput("t1_results", got, 3);
    checkOutput("t1_done_seen", doneSeen, 1);
    checkOutput("t1_done_pulse", done, 0);
    checkOutput("t1_busy_end", busy, 0);

    // Vector table: settle with NCO gaps and junk samples, then samples interleaved with mismatched valids
    for (int v = 0; v < 6; v++) begin
      startSweep(32'h2000, 32'h0, 1);
      for (int k = 0; k < 2 * SC; k++) applyStimulus(0, 0, k % 2, 2'b11, -5000, -5000, 0);
      for (int s = 0; s < NS; s++) begin
        applyStimulus(0, 0, 0, 2'b11, vecs[v].si[s], vecs[v].sq[s], 0);
        if (s < NS - 1) applyStimulus(0, 0, 0, (s % 2) ? 2'b01 : 2'b10, 1234, 1234, 0);
      end
      checkOutput({vecs[v].name, "_valid"}, res.resultValid, 1);
      checkOutput({vecs[v].name, "_I"}, res.resultI, vecs[v].ei);
      checkOutput({vecs[v].name, "_Q"}, res.resultQ, vecs[v].eq);
      applyStimulus(0, 0, 0, 2'b00, 0, 0, 1);
      checkOutput({vecs[v].name, "_done"}, done, 1);
    end

    // Back-pressure: result must hold while ready is low; a start pulse mid-sweep is ignored
    startSweep(32'h4000, 32'h40, 2);
    settleAndFill(7, -7);
    checkOutput("stall_valid0", res.resultValid, 1);
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        startInc = 32'h9999; stepInc = 32'h7; numSteps = 16'd9;
      end
      applyStimulus(c == 5, 0, 1, 2'b11, 1, 1, 0);
      checkOutput("stall_valid", res.resultValid, 1);
      checkOutput("stall_I", res.resultI, 7);
      checkOutput("stall_Q", res.resultQ, -7);
      checkOutput("stall_idx", res.resultIdx, 0);
      checkOutput("stall_phase", phaseInc, 32'h4000);
    end
    applyStimulus(0, 0, 1, 2'b00, 0, 0, 1);
    checkOutput("stall_accept_valid", res.resultValid, 0);
    checkOutput("stall_accept_busy", busy, 1);
    checkOutput("stall_step_phase", phaseInc, 32'h4040);
    settleAndFill(-7, 7);
    checkOutput("stall_idx1", res.resultIdx, 1);
    checkOutput("stall_I1", res.resultI, -7);
    applyStimulus(0, 0, 1, 2'b00, 0, 0, 1);
    checkOutput("stall_done", done, 1);
    checkOutput("stall_phase_hold", phaseInc, 32'h4040);

    // Phase increment wraps modulo 2^32, then abort during settle
    startSweep(32'hFFFFFF00, 32'h200, 2);
    settleAndFill(0, 0);
    checkOutput("wrap_phase0", phaseInc, 32'hFFFFFF00);
    applyStimulus(0, 0, 1, 2'b00, 0, 0, 1);
    checkOutput("wrap_phase1", phaseInc, 32'h00000100);
    applyStimulus(0, 1, 1, 2'b00, 0, 0, 0);
    checkOutput("abort_settle_busy", busy, 0);
    checkOutput("abort_settle_phase", phaseInc, 32'h100);
    applyStimulus(0, 0, 1, 2'b00, 0, 0, 0);
    checkOutput("abort_settle_nodone", done, 0);

    // Abort during accumulation
    startSweep(32'h500, 32'h1, 3);
    for (int k = 0; k < SC; k++) applyStimulus(0, 0, 1, 2'b00, 0, 0, 0);
    applyStimulus(0, 0, 1, 2'b11, 9, 9, 0);
    applyStimulus(0, 0, 1, 2'b11, 9, 9, 0);
    applyStimulus(0, 1, 1, 2'b11, 9, 9, 1);
    checkOutput("abort_acc_busy", busy, 0);
    checkOutput("abort_acc_valid", res.resultValid, 0);
    checkOutput("abort_acc_done", done, 0);
    checkOutput("abort_acc_phase", phaseInc, 32'h500);
    applyStimulus(0, 0, 1, 2'b11, 9, 9, 1);
    checkOutput("abort_acc_nodone", done, 0);
    checkOutput("abort_acc_idle", busy, 0);

    // Abort beats a same-cycle acceptance
    startSweep(32'h800, 32'h1, 1);
    settleAndFill(3, 3);
    applyStimulus(0, 1, 1, 2'b00, 0, 0, 1);
    checkOutput("abort_emit_done", done, 0);
    checkOutput("abort_emit_valid", res.resultValid, 0);

    // Reset in EMIT clears every output; reset also overrides start
    startSweep(32'h600, 32'h1, 2);
    settleAndFill(50, 60);
    checkOutput("rst_emit_pre", res.resultValid, 1);
    reset = 1'b1;
    applyStimulus(1, 0, 1, 2'b11, 50, 60, 0);
    reset = 1'b0;
    checkOutput("rst_emit_valid", res.resultValid, 0);
    checkOutput("rst_emit_busy", busy, 0);
    checkOutput("rst_emit_phase", phaseInc, 0);
    checkOutput("rst_emit_I", res.resultI, 0);
    checkOutput("rst_emit_Q", res.resultQ, 0);
    checkOutput("rst_emit_idx", res.resultIdx, 0);
    checkOutput("rst_emit_done", done, 0);

    // Zero-step start pulses done only
    startSweep(32'h700, 32'h1, 0);
    checkOutput("zero_done", done, 1);
    checkOutput("zero_busy", busy, 0);
    applyStimulus(0, 0, 1, 2'b00, 0, 0, 0);
    checkOutput("zero_done_clr", done, 0);
    checkOutput("zero_busy2", busy, 0);

    // Randomized sweeps against the reference model
    doReset();
    mActive = 0; mPending = 0; mDone = 0; mPhase = '0; mStep = '0;
    for (int sw = 0; sw < 4; sw++) begin
      startInc = $urandom;
      stepInc  = $urandom;
      numSteps = STW'($urandom_range(1, 4));
      cycles = 0;
      do begin
        st = (cycles == 0) || ($urandom_range(0, 29) == 0);
        if (st && cycles != 0) begin
          startInc = $urandom;
          stepInc  = $urandom;
          numSteps = STW'($urandom_range(1, 9));
        end
        nco = ($urandom_range(0, 9) < 7);
        fv  = $urandom_range(0, 1) ? 2'b11 : 2'($urandom_range(0, 3));
        si  = int'($urandom_range(0, 16383)) - 8192;
        sq  = int'($urandom_range(0, 16383)) - 8192;
        rdy = $urandom_range(0, 1);
        applyStimulus(st, 0, nco, fv, si, sq, rdy);
        modelEdge(st, nco, fv, si, sq, rdy);
        checkOutput("rnd_valid", res.resultValid, mPending);
        checkOutput("rnd_busy", busy, mActive);
        checkOutput("rnd_done", done, mDone);
        checkOutput("rnd_phase", phaseInc, mPhase);
        if (mPending) begin
          checkOutput("rnd_I", res.resultI, mResI);
          checkOutput("rnd_Q", res.resultQ, mResQ);
          checkOutput("rnd_idx", res.resultIdx, mIdx);
        end
        cycles++;
      end while (mActive && cycles < 3000);
      checkOutput("rnd_sweep_finished", mActive, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
